receiver_buffer: RTL and testbench

Receive-side counterpart of the transmit buffer: collects bytes from the UART receiver, assembles each group of 16 into a 128-bit block, and queues complete blocks in a block FIFO. The AES core reads blocks from the FIFO. The block sits between the UART RX byte interface and the AES core input, and absorbs bursts while the AES core is busy.

---
 rtl/receiver_buffer_pkg.sv | 15 +
 rtl/fifo.sv | 61 ++++++
 rtl/receiver_buffer_rx_shift.sv | 82 ++++++++
 rtl/receiver_buffer.sv | 60 ++++++
 tb/tb_receiver_buffer.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/receiver_buffer_pkg.sv
// ============================================================================
// Module      : receiver_buffer_pkg
// Description : Block/byte geometry shared by the receive and transmit buffers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package receiver_buffer_pkg;
    localparam int BLOCK_BITS      = 128;
    localparam int BYTE_BITS       = 8;
    localparam int BYTES_PER_BLOCK = 16;
    localparam int CNT_BITS        = $clog2(BYTES_PER_BLOCK);
endpackage

`default_nettype wire

// File: rtl/fifo.sv
// ============================================================================
// Module      : fifo
// Description : Show-ahead FIFO with wrap-bit pointers and sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             r_overflow;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_wr_ok;
    logic w_rd_ok;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
    // A read in the same cycle frees the slot a full-FIFO write needs.
    assign w_rd_ok = i_rd && !w_empty;
    assign w_wr_ok = i_wr && (!w_full || i_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (i_wr && !w_wr_ok) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

    assign o_rdata    = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty    = w_empty;
    assign o_overflow = r_overflow;
endmodule

`default_nettype wire

// File: rtl/receiver_buffer_rx_shift.sv
// ============================================================================
// Module      : rx_shift
// Description : MSB-first byte-to-block assembler with one-cycle write strobe.
//               Optional partial-block timeout built when RX_TIMEOUT_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_shift
    import receiver_buffer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [BYTE_BITS-1:0]  i_byte,
    output logic                  o_write,
    output logic [BLOCK_BITS-1:0] o_block,
    output logic                  o_busy,
    output logic                  o_timeout
);
    logic [CNT_BITS-1:0]   r_count;
    logic [BLOCK_BITS-1:0] r_shift;
    logic                  r_write;
    logic                  w_busy;
    logic                  w_last;
    logic                  w_tmo;

    assign w_busy = (r_count != '0);
    assign w_last = i_valid && (r_count == CNT_BITS'(BYTES_PER_BLOCK - 1));

`ifdef RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] c_TMO = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] r_tmo_cnt;
    logic          r_timeout;

    assign w_tmo = w_busy && (r_tmo_cnt == c_TMO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_tmo;
            if (i_valid || !w_busy || w_tmo) r_tmo_cnt <= '0;
            else                             r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign o_timeout = r_timeout;
`else
    assign w_tmo     = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_shift <= '0;
            r_write <= 1'b0;
        end else begin
            r_write <= w_last && !w_tmo;
            // A byte arriving with the timeout starts a fresh block at count 1.
            if (w_tmo) begin
                r_count <= i_valid ? CNT_BITS'(1) : '0;
                r_shift <= i_valid ? {{(BLOCK_BITS-BYTE_BITS){1'b0}}, i_byte} : '0;
            end else if (i_valid) begin
                r_count <= r_count + 1'b1;
                r_shift <= {r_shift[BLOCK_BITS-BYTE_BITS-1:0], i_byte};
            end
        end
    end

    assign o_write = r_write;
    assign o_block = r_shift;
    assign o_busy  = w_busy;
endmodule

`default_nettype wire

// File: rtl/receiver_buffer.sv
// ============================================================================
// Module      : receiver_buffer
// Description : UART RX bytes -> 128-bit blocks -> block FIFO for the AES core.
//               Optional macro: RX_TIMEOUT_EN (partial-block discard timeout).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module receiver_buffer
    import receiver_buffer_pkg::*;
#(
    parameter int          DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BYTE_BITS-1:0]  byte_UART_to_shiftReg,
    input  logic                  rx_done,
    input  logic                  block_read,
    output logic [BLOCK_BITS-1:0] block_buffer_to_aes,
    output logic                  block_valid,
    output logic                  rx_busy,
    output logic                  overflow,
    output logic                  rx_timeout
);
    logic                  w_write;
    logic [BLOCK_BITS-1:0] w_block;
    logic                  w_empty;

    rx_shift #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx_shift (
        .clk       (clk),
        .rst       (reset),
        .i_valid   (rx_done),
        .i_byte    (byte_UART_to_shiftReg),
        .o_write   (w_write),
        .o_block   (w_block),
        .o_busy    (rx_busy),
        .o_timeout (rx_timeout)
    );

    fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BLOCK_BITS)
    ) u_fifo (
        .clk        (clk),
        .rst        (reset),
        .i_wr       (w_write),
        .i_wdata    (w_block),
        .i_rd       (block_read),
        .o_rdata    (block_buffer_to_aes),
        .o_empty    (w_empty),
        .o_overflow (overflow)
    );

    assign block_valid = !w_empty;
endmodule

`default_nettype wire

// File: tb/tb_receiver_buffer.sv
// ============================================================================
// Module      : tb_receiver_buffer
// Description : Directed self-checking bench for receiver_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_receiver_buffer;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   din = 8'h00;
    logic         rx_done = 1'b0;
    logic         block_read = 1'b0;
    logic [127:0] dout;
    logic         valid;
    logic         busy;
    logic         ovf;
    logic         tmo;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    receiver_buffer #(
        .DEPTH          (4),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .byte_UART_to_shiftReg (din),
        .rx_done               (rx_done),
        .block_read            (block_read),
        .block_buffer_to_aes   (dout),
        .block_valid           (valid),
        .rx_busy               (busy),
        .overflow              (ovf),
        .rx_timeout            (tmo)
    );

    function automatic logic [127:0] blk(input logic [7:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r = {r[119:0], 8'(s + 8'(i))};
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bytes(input int n, input logic [7:0] start);
        for (int i = 0; i < n; i++) begin
            din     = start + 8'(i);
            rx_done = 1'b1;
            tick(1);
        end
        rx_done = 1'b0;
        din     = 8'h00;
    endtask

    task automatic pop();
        block_read = 1'b1;
        tick(1);
        block_read = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        vectors++;
        if ({valid, busy, ovf, tmo} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 0000", {valid, busy, ovf, tmo});
        end
        vectors++;
        if (dout !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h expected 0", dout);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_block();
        send_bytes(15, 8'h00);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_after_15: got %b expected 1", busy);
        end
        send_bytes(1, 8'h0F);
        vectors++;
        if ({busy, valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL after_16th_edge busy/valid: got %b expected 00", {busy, valid});
        end
        tick(1);
        vectors++;
        if (valid !== 1'b1) begin
            miscompares++;
            $display("FAIL single_valid: got %b expected 1", valid);
        end
        vectors++;
        if (dout !== 128'h000102030405060708090A0B0C0D0E0F) begin
            miscompares++;
            $display("FAIL single_data: got %h expected 000102030405060708090a0b0c0d0e0f", dout);
        end
        pop();
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_pop_empty: got %b expected 0", valid);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        send_bytes(80, 8'h10);
        tick(2);
        vectors++;
        if ({ovf, valid} !== 2'b11) begin
            miscompares++;
            $display("FAIL ovf_set ovf/valid: got %b expected 11", {ovf, valid});
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (dout !== blk(8'h10 + 8'(16 * k))) begin
                miscompares++;
                $display("FAIL ovf_read%0d: got %h expected %h", k, dout, blk(8'h10 + 8'(16 * k)));
            end
            pop();
        end
        vectors++;
        if ({ovf, valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL ovf_sticky ovf/valid: got %b expected 10", {ovf, valid});
        end
    endtask

    task automatic test_full_read_write();
        logic [7:0] exp_s [4];
        exp_s[0] = 8'h20; exp_s[1] = 8'h30; exp_s[2] = 8'h40; exp_s[3] = 8'h60;
        do_reset();
        send_bytes(64, 8'h10);
        tick(2);
        send_bytes(16, 8'h60);
        block_read = 1'b1;
        tick(1);
        block_read = 1'b0;
        vectors++;
        if (ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL full_rw_ovf: got %b expected 0", ovf);
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (dout !== blk(exp_s[k])) begin
                miscompares++;
                $display("FAIL full_rw_read%0d: got %h expected %h", k, dout, blk(exp_s[k]));
            end
            pop();
        end
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++;
            $display("FAIL full_rw_drained: got %b expected 0", valid);
        end
    endtask

    task automatic test_reset_midblock();
        do_reset();
        send_bytes(7, 8'h33);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_busy: got %b expected 1", busy);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({busy, valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL async_reset busy/valid: got %b expected 00", {busy, valid});
        end
        tick(1);
        reset = 1'b0;
        send_bytes(16, 8'hA0);
        tick(1);
        vectors++;
        if (dout !== blk(8'hA0)) begin
            miscompares++;
            $display("FAIL mid_block_data: got %h expected %h", dout, blk(8'hA0));
        end
        pop();
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_single_block: got %b expected 0", valid);
        end
    endtask

    task automatic test_empty_read();
        block_read = 1'b1;
        tick(10);
        block_read = 1'b0;
        vectors++;
        if (valid !== 1'b0 || dout !== 128'h0) begin
            miscompares++;
            $display("FAIL empty_read valid/data: got %b/%h expected 0/0", valid, dout);
        end
        send_bytes(16, 8'hC0);
        tick(1);
        vectors++;
        if (valid !== 1'b1 || dout !== blk(8'hC0)) begin
            miscompares++;
            $display("FAIL after_empty_read: got %b/%h expected 1/%h", valid, dout, blk(8'hC0));
        end
        pop();
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++;
            $display("FAIL after_empty_pop: got %b expected 0", valid);
        end
    endtask

    task automatic test_timeout();
        int pulses;
        pulses = 0;
        send_bytes(5, 8'h55);
        repeat (60) begin
            tick(1);
            if (tmo === 1'b1) pulses++;
        end
`ifdef RX_TIMEOUT_EN
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL timeout_pulses: got %0d expected 1", pulses);
        end
        vectors++;
        if ({busy, valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL timeout busy/valid: got %b expected 00", {busy, valid});
        end
        send_bytes(16, 8'hD0);
        tick(1);
        vectors++;
        if (dout !== blk(8'hD0)) begin
            miscompares++;
            $display("FAIL timeout_next_block: got %h expected %h", dout, blk(8'hD0));
        end
        pop();
`else
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL no_timeout_pulses: got %0d expected 0", pulses);
        end
        vectors++;
        if ({busy, valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL partial_waits busy/valid: got %b expected 10", {busy, valid});
        end
        do_reset();
`endif
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_overflow();
        test_full_read_write();
        test_reset_midblock();
        test_empty_read();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

`default_nettype wire
